// File: rtl/kvadd2_example_pkg.sv
// Shared constants for the kvadd2 example vector-join adder stage.
// Default widths, lane count and output skid depth.
package kvadd2_example_pkg;

  localparam int unsigned LP_TDATA_W    = 512;
  localparam int unsigned LP_LANE_W     = 32;
  localparam int unsigned LP_COUNT_W    = 32;
  localparam int unsigned LP_NUM_LANES  = LP_TDATA_W / LP_LANE_W;
  localparam int unsigned LP_SKID_DEPTH = 2;

endpackage

// File: rtl/kvadd2_example_axis_skid.sv
// Two-entry registered AXI4-Stream buffer with a registered not-full flag.
// Output fields come straight from storage, so they hold while stalled.
module kvadd2_example_axis_skid
  import kvadd2_example_pkg::*;
#(
  parameter int unsigned DATA_W = LP_TDATA_W
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                push_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] keep_i,
  input  logic                last_i,
  output logic                not_full_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_W-1:0]   m_data_o,
  output logic [DATA_W/8-1:0] m_keep_o,
  output logic                m_last_o
);

  logic [DATA_W-1:0]   data_q [LP_SKID_DEPTH];
  logic [DATA_W/8-1:0] keep_q [LP_SKID_DEPTH];
  logic                last_q [LP_SKID_DEPTH];

  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       not_full_q;
  logic       pop;

  always_comb begin
    pop   = (cnt_q != 2'd0) && m_ready_i;
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q      <= 2'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      not_full_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      not_full_q <= (cnt_d != 2'(LP_SKID_DEPTH));
      if (push_i) wr_q <= ~wr_q;
      if (pop)    rd_q <= ~rd_q;
    end
  end

  // Payload needs no reset; occupancy alone decides validity.
  always_ff @(posedge aclk) begin
    if (push_i) begin
      data_q[wr_q] <= data_i;
      keep_q[wr_q] <= keep_i;
      last_q[wr_q] <= last_i;
    end
  end

  assign not_full_o = not_full_q;
  assign m_valid_o  = (cnt_q != 2'd0);
  assign m_data_o   = data_q[rd_q];
  assign m_keep_o   = keep_q[rd_q];
  assign m_last_o   = last_q[rd_q];

endmodule

// File: rtl/kvadd2_example_vjoin.sv
// Joins streams A and B beat-by-beat and emits the lane-wise sum.
// Tracks joined beats and sticky tlast misalignment between A and B.
module kvadd2_example_vjoin
  import kvadd2_example_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = LP_TDATA_W,
  parameter int unsigned C_ADDER_BIT_WIDTH  = LP_LANE_W,
  parameter int unsigned C_COUNT_WIDTH      = LP_COUNT_W
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_a_axis_tvalid,
  output logic                            s_a_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_a_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_a_axis_tkeep,
  input  logic                            s_a_axis_tlast,
  input  logic                            s_b_axis_tvalid,
  output logic                            s_b_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_b_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_b_axis_tkeep,
  input  logic                            s_b_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_COUNT_WIDTH-1:0]        beat_count,
  output logic                            tlast_mismatch
);

  localparam int unsigned LANES =
    C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int unsigned LW = C_ADDER_BIT_WIDTH;

  logic                          not_full;
  logic                          join_c;
  logic [C_AXIS_TDATA_WIDTH-1:0] sum;
  logic [C_COUNT_WIDTH-1:0]      cnt_q;
  logic [C_COUNT_WIDTH-1:0]      cnt_d;
  logic                          mis_q;
  logic                          mis_d;

  // Ready never looks at m_axis_tready, only the registered not-full.
  assign join_c = s_a_axis_tvalid & s_b_axis_tvalid
                & not_full & ~areset;

  assign s_a_axis_tready = join_c;
  assign s_b_axis_tready = join_c;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign sum[g*LW +: LW] =
      s_a_axis_tdata[g*LW +: LW] + s_b_axis_tdata[g*LW +: LW];
  end

  always_comb begin
    cnt_d = cnt_q;
    mis_d = mis_q;
    if (join_c) begin
      cnt_d = cnt_q + 1'b1;
      if (s_a_axis_tlast != s_b_axis_tlast) mis_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  assign beat_count     = cnt_q;
  assign tlast_mismatch = mis_q;

  kvadd2_example_axis_skid #(
    .DATA_W (C_AXIS_TDATA_WIDTH)
  ) u_skid (
    .aclk       (aclk),
    .areset     (areset),
    .push_i     (join_c),
    .data_i     (sum),
    .keep_i     (s_a_axis_tkeep & s_b_axis_tkeep),
    .last_i     (s_a_axis_tlast | s_b_axis_tlast),
    .not_full_o (not_full),
    .m_valid_o  (m_axis_tvalid),
    .m_ready_i  (m_axis_tready),
    .m_data_o   (m_axis_tdata),
    .m_keep_o   (m_axis_tkeep),
    .m_last_o   (m_axis_tlast)
  );

endmodule

// File: tb/tb_kvadd2_example_vjoin.sv
// Scoreboard bench for kvadd2_example_vjoin.
// Expected beats are queued on join and compared on output handshake.
module tb_kvadd2_example_vjoin;

  localparam int W = 512;
  localparam int K = W / 8;
  localparam int L = 32;
  localparam int N = W / L;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         a_v = 1'b0, b_v = 1'b0;
  logic         a_rdy, b_rdy;
  logic [W-1:0] a_d = '0, b_d = '0;
  logic [K-1:0] a_k = '0, b_k = '0;
  logic         a_l = 1'b0, b_l = 1'b0;
  logic         m_v;
  logic         m_rdy = 1'b0;
  logic [W-1:0] m_d;
  logic [K-1:0] m_k;
  logic         m_l;
  logic [31:0]  cnt;
  logic         mis;

  typedef struct packed {
    logic [W-1:0] d;
    logic [K-1:0] k;
    logic         l;
  } beat_t;

  beat_t        sb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           occ = 0;
  int           full_seen = 0;
  int           rdy_mode = 1;
  logic         stall_p = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic [W-1:0] va, vb;

  kvadd2_example_vjoin dut (
    .aclk            (aclk),
    .areset          (areset),
    .s_a_axis_tvalid (a_v),
    .s_a_axis_tready (a_rdy),
    .s_a_axis_tdata  (a_d),
    .s_a_axis_tkeep  (a_k),
    .s_a_axis_tlast  (a_l),
    .s_b_axis_tvalid (b_v),
    .s_b_axis_tready (b_rdy),
    .s_b_axis_tdata  (b_d),
    .s_b_axis_tkeep  (b_k),
    .s_b_axis_tlast  (b_l),
    .m_axis_tvalid   (m_v),
    .m_axis_tready   (m_rdy),
    .m_axis_tdata    (m_d),
    .m_axis_tkeep    (m_k),
    .m_axis_tlast    (m_l),
    .beat_count      (cnt),
    .tlast_mismatch  (mis)
  );

  initial forever #5 aclk = ~aclk;

  task automatic check_eq(input string tag,
                          input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] lane_sum(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*L +: L] = a[i*L +: L] + b[i*L +: L];
    return r;
  endfunction

  function automatic logic [W-1:0] splat(input logic [L-1:0] v);
    return {N{v}};
  endfunction

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       m_rdy = 1'b0;
      1:       m_rdy = 1'b1;
      default: m_rdy = ~m_rdy;
    endcase
  end

  // Model of occupancy plus scoreboard, sampled mid-cycle.
  always @(negedge aclk) begin
    beat_t e;
    logic  jn, pp;
    if (areset) begin
      sb.delete();
      occ = 0;
      stall_p = 1'b0;
    end else begin
      jn = a_v & b_v & a_rdy;
      pp = m_v & m_rdy;
      check_eq("rdy_ab", a_rdy, b_rdy);
      if (occ == 2) begin
        full_seen++;
        check_eq("rdy_full", a_rdy, 1'b0);
      end
      if (a_v != b_v) check_eq("lone_rdy", a_rdy | b_rdy, 1'b0);
      check_eq("m_valid", m_v, occ != 0);
      if (stall_p && m_v) check_eq("hold", m_d, hold_d);
      stall_p = m_v & ~m_rdy;
      hold_d  = m_d;
      if (pp) begin
        if (sb.size() == 0) begin
          check_eq("extra_beat", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check_eq("data", m_d, e.d);
          check_eq("keep", m_k, e.k);
          check_eq("last", m_l, e.l);
        end
      end
      if (jn) begin
        e.d = lane_sum(a_d, b_d);
        e.k = a_k & b_k;
        e.l = a_l | b_l;
        sb.push_back(e);
      end
      occ = occ + int'(jn) - int'(pp);
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [K-1:0] ka, input logic [K-1:0] kb,
                      input logic la, input logic lb);
    bit ok = 0;
    a_v = 1'b1; a_d = a; a_k = ka; a_l = la;
    b_v = 1'b1; b_d = b; b_k = kb; b_l = lb;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (a_rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", 1'b0, 1'b1);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    a_v = 1'b0;
    b_v = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge aclk);
    if (sb.size() != 0) check_eq("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    // Reset with both valids high: nothing may be accepted.
    a_v = 1'b1;
    b_v = 1'b1;
    repeat (2) @(negedge aclk);
    check_eq("rst_rdy", a_rdy | b_rdy, 1'b0);
    @(posedge aclk);
    #1;
    check_eq("rst_mv", m_v, 1'b0);
    check_eq("rst_cnt", cnt, '0);
    check_eq("rst_mis", mis, 1'b0);
    idle();
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Single beat, 1-cycle latency
    send(splat(32'h1), splat(32'h2), '1, '1, 1'b1, 1'b1);
    idle();
    check_eq("t1_lat", m_v, 1'b1);
    check_eq("t1_data", m_d, splat(32'h3));
    check_eq("t1_last", m_l, 1'b1);
    check_eq("t1_cnt", cnt, 32'd1);
    check_eq("t1_mis", mis, 1'b0);
    drain();

    // Lane wrap, no inter-lane carry, keep AND
    va = '0;
    vb = '0;
    va[31:0] = 32'hFFFF_FFFF;
    vb[31:0] = 32'h0000_0002;
    send(va, vb, {4{16'hF0FF}}, {4{16'h3C3F}}, 1'b0, 1'b0);
    idle();
    check_eq("t2_l01", m_d[63:0], 64'h0000_0000_0000_0001);
    check_eq("t2_keep", m_k, {4{16'h303F}});
    drain();
    check_eq("t2_cnt", cnt, 32'd2);

    // A alone is held until B shows up
    do_reset();
    a_v = 1'b1;
    a_d = splat(32'h5);
    a_k = '1;
    repeat (5) begin
      @(negedge aclk);
      check_eq("t3_hold", a_rdy | b_rdy, 1'b0);
    end
    check_eq("t3_cnt0", cnt, '0);
    @(posedge aclk);
    #1;
    send(splat(32'h5), splat(32'h7), '1, '1, 1'b1, 1'b1);
    idle();
    drain();
    check_eq("t3_cnt", cnt, 32'd1);

    // Back-pressure with toggling m_ready
    do_reset();
    full_seen = 0;
    rdy_mode = 2;
    for (int n = 0; n < 16; n++) begin
      va = '0;
      va[31:0] = 32'(n);
      send(va, splat(32'h10), '1, '1, n == 15, n == 15);
    end
    idle();
    drain();
    rdy_mode = 1;
    check_eq("t4_cnt", cnt, 32'd16);
    check_eq("t4_full", full_seen > 0, 1'b1);

    // tlast misalignment on beat 4
    do_reset();
    for (int n = 0; n < 8; n++) begin
      send(splat(32'(n)), splat(32'h1), '1, '1, n == 4, 1'b0);
      if (n == 3) check_eq("t5_mis_pre", mis, 1'b0);
      if (n == 4) check_eq("t5_mis_set", mis, 1'b1);
    end
    idle();
    drain();
    check_eq("t5_mis_hold", mis, 1'b1);

    // Reset drops buffered beats
    do_reset();
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    send(splat(32'hA), splat(32'h1), '1, '1, 1'b1, 1'b0);
    send(splat(32'hB), splat(32'h1), '1, '1, 1'b0, 1'b0);
    idle();
    check_eq("t6_pre_mv", m_v, 1'b1);
    check_eq("t6_pre_cnt", cnt, 32'd2);
    check_eq("t6_pre_mis", mis, 1'b1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check_eq("t6_mv", m_v, 1'b0);
    check_eq("t6_cnt", cnt, '0);
    check_eq("t6_mis", mis, 1'b0);
    areset = 1'b0;
    rdy_mode = 1;
    repeat (6) @(posedge aclk);
    #1;
    check_eq("t6_post_mv", m_v, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
